// File: rtl/wut_ctrl.sv
// Wake-up timer sequencer: latches a period, hands it to the timer with a
// req/ack handshake, counts expiries, re-arms, and reports interrupt/error.
module wut_ctrl #(
  parameter int WIDTH       = 9,
  parameter int RPT_W       = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             perm_clk,
  input  logic             perm_rstb,
  input  logic             cfg_enable,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [RPT_W-1:0] cfg_repeat,
  input  logic             sw_start,
  input  logic             sw_stop,
  input  logic             it_clear,
  output logic [WIDTH-1:0] perm_wut_limit,
  output logic             perm_wut_disable,
  output logic             perm_wut_start_req,
  input  logic             perm_wut_start_ack,
  output logic             wut_busy,
  output logic             wut_it,
  output logic             wut_err,
  output logic [RPT_W-1:0] wut_event_cnt
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             dis_q;
  logic             req_q;
  logic             busy_q;
  logic             it_q;
  logic             err_q;
  logic [RPT_W-1:0] cnt_q;
  logic [RPT_W-1:0] rpt_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ack_q;

  logic             stop_d;
  logic             expiry_d;
  logic [RPT_W-1:0] cnt_d;
  logic             done_d;

  function automatic logic [RPT_W-1:0] sat_inc(input logic [RPT_W-1:0] v);
    return (&v) ? v : v + {{(RPT_W-1){1'b0}}, 1'b1};
  endfunction

  assign stop_d   = sw_stop | ~cfg_enable;
  assign expiry_d = ack_q & ~perm_wut_start_ack;
  assign cnt_d    = sat_inc(cnt_q);
  assign done_d   = (rpt_q != '0) && (cnt_d == rpt_q);

  always_ff @(posedge perm_clk or negedge perm_rstb) begin
    if (!perm_rstb) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      dis_q   <= 1'b1;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      it_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= perm_wut_start_ack;
      // Clear first so that a simultaneous set below takes precedence.
      if (it_clear) begin
        it_q  <= 1'b0;
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (sw_start && cfg_enable) begin
            if (cfg_period != '0) begin
              state_q <= S_REQ;
              limit_q <= cfg_period;
              rpt_q   <= cfg_repeat;
              cnt_q   <= '0;
              tmo_q   <= '0;
              req_q   <= 1'b1;
              dis_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (stop_d) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            dis_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (perm_wut_start_ack) begin
            state_q <= S_RUN;
            req_q   <= 1'b0;
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            dis_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_RUN: begin
          // A stop masks any expiry seen in the same cycle.
          if (stop_d) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            dis_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (expiry_d) begin
            it_q  <= 1'b1;
            cnt_q <= cnt_d;
            if (done_d) begin
              state_q <= S_IDLE;
              dis_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              tmo_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          dis_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign perm_wut_limit     = limit_q;
  assign perm_wut_disable   = dis_q;
  assign perm_wut_start_req = req_q;
  assign wut_busy           = busy_q;
  assign wut_it             = it_q;
  assign wut_err            = err_q;
  assign wut_event_cnt      = cnt_q;

endmodule

// File: tb/tb_wut_ctrl.sv
// Randomized bench for wut_ctrl with a transaction-level model of the
// expected interrupt, error, counter and handshake state.
module tb_wut_ctrl;
  localparam int WIDTH       = 9;
  localparam int RPT_W       = 3;
  localparam int ACK_TIMEOUT = 8;
  localparam int CNT_MAX     = (1 << RPT_W) - 1;

  logic             clk;
  logic             rstb;
  logic             cfg_enable;
  logic [WIDTH-1:0] cfg_period;
  logic [RPT_W-1:0] cfg_repeat;
  logic             sw_start;
  logic             sw_stop;
  logic             it_clear;
  logic [WIDTH-1:0] limit;
  logic             dis;
  logic             req;
  logic             ack;
  logic             busy;
  logic             it;
  logic             err;
  logic [RPT_W-1:0] cnt;

  wut_ctrl #(.WIDTH(WIDTH), .RPT_W(RPT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .perm_clk           (clk),
    .perm_rstb          (rstb),
    .cfg_enable         (cfg_enable),
    .cfg_period         (cfg_period),
    .cfg_repeat         (cfg_repeat),
    .sw_start           (sw_start),
    .sw_stop            (sw_stop),
    .it_clear           (it_clear),
    .perm_wut_limit     (limit),
    .perm_wut_disable   (dis),
    .perm_wut_start_req (req),
    .perm_wut_start_ack (ack),
    .wut_busy           (busy),
    .wut_it             (it),
    .wut_err            (err),
    .wut_event_cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, advanced only by the abstract rules of the block.
  int m_cnt;
  int m_rpt;
  int m_limit;
  bit m_it;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_req"}, req, 0);
    check_eq({tag, "_dis"}, dis, 1);
    check_eq({tag, "_cnt"}, cnt, m_cnt);
    check_eq({tag, "_it"}, it, m_it);
    check_eq({tag, "_err"}, err, m_err);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_limit"}, limit, 0);
    check_eq({tag, "_dis"}, dis, 1);
    check_eq({tag, "_req"}, req, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_it"}, it, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_cnt"}, cnt, 0);
  endtask

  task automatic start_job(input int period, input int rpt);
    cfg_period = WIDTH'(period);
    cfg_repeat = RPT_W'(rpt);
    sw_start   = 1'b1;
    tick();
    sw_start = 1'b0;
    m_cnt    = 0;
    m_rpt    = rpt;
    m_limit  = period;
    check_eq("start_busy", busy, 1);
    check_eq("start_req", req, 1);
    check_eq("start_dis", dis, 0);
    check_eq("start_limit", limit, m_limit);
    check_eq("start_cnt", cnt, 0);
  endtask

  task automatic clear_flags();
    it_clear = 1'b1;
    tick();
    it_clear = 1'b0;
    m_it  = 0;
    m_err = 0;
    check_eq("clr_it", it, 0);
    check_eq("clr_err", err, 0);
  endtask

  // One timer period: ack after 'delay' cycles, held for 'len' cycles, then dropped.
  task automatic do_period(input int delay, input int len, input bit clr);
    bit done;
    ack = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    check_eq("pre_ack_req", req, 1);
    ack = 1'b1;
    tick();
    check_eq("ack_req_drop", req, 0);
    check_eq("ack_busy", busy, 1);
    for (int i = 1; i < len; i++) tick();
    ack      = 1'b0;
    it_clear = clr;
    tick();
    it_clear = 1'b0;
    if (clr) m_err = 0;
    m_it  = 1;
    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    done  = (m_rpt != 0) && (m_cnt == m_rpt);
    check_eq("exp_it", it, m_it);
    check_eq("exp_cnt", cnt, m_cnt);
    check_eq("exp_busy", busy, !done);
    check_eq("exp_req", req, !done);
    check_eq("exp_dis", dis, done);
    check_eq("exp_err", err, m_err);
    check_eq("exp_limit", limit, m_limit);
  endtask

  initial begin
    int period;
    int rpt;
    int n;
    int used;

    rstb       = 1'b0;
    cfg_enable = 1'b0;
    cfg_period = '0;
    cfg_repeat = '0;
    sw_start   = 1'b0;
    sw_stop    = 1'b0;
    it_clear   = 1'b0;
    ack        = 1'b0;
    m_cnt = 0; m_rpt = 0; m_limit = 0; m_it = 0; m_err = 0;
    tick();
    tick();
    check_reset_vals("reset");
    rstb       = 1'b1;
    cfg_enable = 1'b1;
    tick();

    start_job(5, 1);
    do_period(2, 3, 1'b0);
    check_idle("single");

    start_job(9, 3);
    for (int p = 0; p < 3; p++) do_period(p, 2, 1'b0);
    check_idle("rep3");

    start_job(17, 0);
    for (int p = 0; p < 10; p++) do_period(1, 1, 1'b0);
    check_eq("sat_cnt", cnt, CNT_MAX);
    sw_stop = 1'b1;
    tick();
    sw_stop = 1'b0;
    check_idle("sat_stop");

    clear_flags();
    start_job(33, 2);
    ack = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
    check_eq("tmo_err_early", err, 0);
    check_eq("tmo_busy_early", busy, 1);
    tick();
    m_err = 1;
    check_idle("tmo");

    clear_flags();
    cfg_period = '0;
    sw_start   = 1'b1;
    tick();
    sw_start = 1'b0;
    m_err    = 1;
    check_idle("badcfg");
    tick();
    tick();
    check_eq("badcfg_req_later", req, 0);
    cfg_enable = 1'b0;
    cfg_period = 9'd5;
    sw_start   = 1'b1;
    tick();
    sw_start   = 1'b0;
    cfg_enable = 1'b1;
    check_idle("dis_start");

    clear_flags();
    start_job(7, 0);
    ack = 1'b1;
    tick();
    tick();
    ack     = 1'b0;
    sw_stop = 1'b1;
    tick();
    sw_stop = 1'b0;
    check_idle("stop_race");

    start_job(7, 0);
    cfg_enable = 1'b0;
    tick();
    cfg_enable = 1'b1;
    check_idle("en_drop");

    start_job(11, 2);
    do_period(0, 2, 1'b1);
    do_period(3, 1, 1'b0);
    check_idle("clr_race");

    start_job(13, 0);
    ack = 1'b1;
    tick();
    #2;
    rstb = 1'b0;
    #1;
    check_reset_vals("async_rst");
    ack = 1'b0;
    tick();
    rstb = 1'b1;
    m_cnt = 0; m_it = 0; m_err = 0;
    tick();
    check_idle("post_rst");
    check_eq("post_rst_limit", limit, 0);

    for (int job = 0; job < 12; job++) begin
      period = $urandom_range(1, (1 << WIDTH) - 1);
      rpt    = $urandom_range(0, CNT_MAX);
      start_job(period, rpt);
      used = 0;
      if ($urandom_range(0, 1) == 1) begin
        cfg_period = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        cfg_repeat = RPT_W'($urandom_range(0, CNT_MAX));
        sw_start   = 1'b1;
        tick();
        sw_start = 1'b0;
        used     = 1;
        check_eq("busy_start_limit", limit, m_limit);
        check_eq("busy_start_cnt", cnt, 0);
      end
      n = (rpt != 0) ? rpt : $urandom_range(1, 10);
      for (int p = 0; p < n; p++) begin
        do_period($urandom_range(0, 6 - used), $urandom_range(1, 4),
                  $urandom_range(0, 3) == 0);
        used = 0;
      end
      if (rpt == 0) begin
        sw_stop = 1'b1;
        tick();
        sw_stop = 1'b0;
      end
      check_idle("rnd_end");
      if ($urandom_range(0, 1) == 1) clear_flags();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
